// File: rtl/avst_crdt_tx_gate_if.sv
// Credit-gated transmit interface: link-partner credit control, request/grant
// handshake and status. The master side drives init/update/request; the slave
// side (the gate) returns ack, grant and status.
interface avst_crdt_tx_gate_if #(
    parameter int unsigned UPDATE_CNT_WIDTH = 2,
    parameter int unsigned CRDT_WIDTH       = 12,
    parameter int unsigned REQ_CNT_WIDTH    = 4
);

    // Credit control
    logic                        CRDT_INIT;
    logic                        CRDT_INIT_ACK;
    logic                        CRDT_UPDATE;
    logic [UPDATE_CNT_WIDTH-1:0] CRDT_UPDATE_CNT;

    // Request and status
    logic                        TX_REQ;
    logic [REQ_CNT_WIDTH-1:0]    TX_REQ_CNT;
    logic                        TX_GRANT;
    logic [CRDT_WIDTH-1:0]       CREDITS;
    logic                        INFINITE;
    logic                        READY;
    logic                        OVERFLOW;

    modport master (
        output CRDT_INIT,
        output CRDT_UPDATE,
        output CRDT_UPDATE_CNT,
        output TX_REQ,
        output TX_REQ_CNT,
        input  CRDT_INIT_ACK,
        input  TX_GRANT,
        input  CREDITS,
        input  INFINITE,
        input  READY,
        input  OVERFLOW
    );

    modport slave (
        input  CRDT_INIT,
        input  CRDT_UPDATE,
        input  CRDT_UPDATE_CNT,
        input  TX_REQ,
        input  TX_REQ_CNT,
        output CRDT_INIT_ACK,
        output TX_GRANT,
        output CREDITS,
        output INFINITE,
        output READY,
        output OVERFLOW
    );

endinterface

// File: rtl/avst_crdt_tx_gate.sv
// Credit-based transmit gate. After a link-partner init handshake the block
// accumulates returned credits and grants transmit requests only when enough
// credits are held. An init that returns no credits at all selects infinite
// mode, where requests are always granted and the counter is never decremented.
// The counter saturates at its maximum and raises a sticky overflow flag.
module avst_crdt_tx_gate #(
    parameter int unsigned UPDATE_CNT_WIDTH = 2,
    parameter int unsigned CRDT_WIDTH       = 12,
    parameter int unsigned REQ_CNT_WIDTH    = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    avst_crdt_tx_gate_if.slave    bus
);

    // One guard bit so that add-then-subtract never wraps before saturation.
    localparam int unsigned SumWidth = CRDT_WIDTH + 1;
    localparam logic [SumWidth-1:0] CrdtMax = {1'b0, {CRDT_WIDTH{1'b1}}};

    typedef enum logic [1:0] {
        StIdle,
        StInit,
        StRun
    } state_e;

    state_e                state_q, state_d;
    logic [CRDT_WIDTH-1:0] credits_q, credits_d;
    logic                  infinite_q, infinite_d;
    logic                  overflow_q, overflow_d;
    logic                  ack_pend_q, ack_pend_d;
    logic                  ack_q;

    logic [SumWidth-1:0]   cur_ext;
    logic [SumWidth-1:0]   upd_ext;
    logic [SumWidth-1:0]   req_ext;
    logic [SumWidth-1:0]   dec_ext;
    logic [SumWidth-1:0]   raw_sum;
    logic [CRDT_WIDTH-1:0] sat_val;
    logic                  sat_hit;
    logic                  credits_ok;
    logic                  grant;

    // Credit arithmetic and the combinational grant decision.
    always_comb begin
        cur_ext    = {1'b0, credits_q};
        upd_ext    = bus.CRDT_UPDATE ? SumWidth'(bus.CRDT_UPDATE_CNT) : '0;
        req_ext    = SumWidth'(bus.TX_REQ_CNT);
        credits_ok = infinite_q || (cur_ext >= req_ext);
        // An init request in RUN aborts, so it also blocks the grant.
        grant      = (state_q == StRun) && !RESET && bus.TX_REQ && !bus.CRDT_INIT
                     && credits_ok;
        // Infinite mode never consumes credits.
        dec_ext    = (grant && !infinite_q) ? req_ext : '0;
        // A grant only happens when credits_q >= demand, so this cannot underflow.
        raw_sum    = cur_ext + upd_ext - dec_ext;
        sat_hit    = (raw_sum > CrdtMax);
        sat_val    = sat_hit ? CrdtMax[CRDT_WIDTH-1:0] : raw_sum[CRDT_WIDTH-1:0];
    end

    // Next-state logic for the IDLE/INIT/RUN handshake and the credit counter.
    always_comb begin
        state_d    = state_q;
        credits_d  = credits_q;
        infinite_d = infinite_q;
        overflow_d = overflow_q;
        ack_pend_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.CRDT_INIT) begin
                    state_d    = StInit;
                    credits_d  = '0;
                    infinite_d = 1'b0;
                    ack_pend_d = 1'b1;
                end
            end

            StInit: begin
                // No grant is possible here, so sat_val is simply count + update.
                credits_d  = sat_val;
                overflow_d = overflow_q | sat_hit;
                if (!bus.CRDT_INIT) begin
                    state_d    = StRun;
                    // Zero credits after the final update selects infinite mode.
                    infinite_d = (sat_val == '0);
                end
            end

            StRun: begin
                if (bus.CRDT_INIT) begin
                    // Abort: the update in this cycle is dropped with the old count.
                    state_d    = StInit;
                    credits_d  = '0;
                    infinite_d = 1'b0;
                    ack_pend_d = 1'b1;
                end else begin
                    credits_d  = sat_val;
                    overflow_d = overflow_q | sat_hit;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, counter and flag registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= StIdle;
            credits_q  <= '0;
            infinite_q <= 1'b0;
            overflow_q <= 1'b0;
            ack_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            credits_q  <= credits_d;
            infinite_q <= infinite_d;
            overflow_q <= overflow_d;
            ack_pend_q <= ack_pend_d;
        end
    end

    // Delays the init-entry marker so the ack lands one cycle after INIT is entered.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= ack_pend_q;
        end
    end

    assign bus.CRDT_INIT_ACK = ack_q;
    assign bus.TX_GRANT      = grant;
    assign bus.CREDITS       = credits_q;
    assign bus.INFINITE      = infinite_q;
    assign bus.OVERFLOW      = overflow_q;
    assign bus.READY         = (state_q == StRun) && !RESET;

endmodule

// File: doc/avst_crdt_tx_gate.md
AVST_CRDT_TX_GATE -- requirements
Module: avst_crdt_tx_gate

Interface
REQ-001 Parameter UPDATE_CNT_WIDTH, default 2, width of the credit-update count field.
REQ-002 Parameter CRDT_WIDTH, default 12, width of the internal credit counter.
REQ-003 Parameter REQ_CNT_WIDTH, default 4, width of the per-request credit demand.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset:
- CLK  in  1  clock.
- RESET  in  1  asynchronous, active-high reset.
REQ-005 Credit control ports SHALL be:
- CRDT_INIT  in  1  credit init request from the link partner.
- CRDT_INIT_ACK  out  1  init acknowledge.
- CRDT_UPDATE  in  1  credit return valid.
- CRDT_UPDATE_CNT  in  UPDATE_CNT_WIDTH  credits returned.
REQ-006 Request and status ports SHALL be:
- TX_REQ  in  1  transmit request; held until granted.
- TX_REQ_CNT  in  REQ_CNT_WIDTH  credits needed by the request.
- TX_GRANT  out  1  request granted this cycle.
- CREDITS  out  CRDT_WIDTH  current credit count.
- INFINITE  out  1  infinite-credit mode active.
- READY  out  1  state is RUN.
- OVERFLOW  out  1  sticky counter-saturation flag.

Function
REQ-007 The FSM SHALL have three states, IDLE, INIT and RUN; reset enters IDLE.
REQ-008 IDLE: on CRDT_INIT=1, go to INIT next cycle, clear the counter, and clear INFINITE.
REQ-009 CRDT_INIT_ACK SHALL be a registered one-cycle pulse, asserted in the cycle after the FSM enters INIT.
REQ-010 INIT: each cycle with CRDT_UPDATE=1 SHALL add CRDT_UPDATE_CNT, zero-extended, to the counter.
REQ-011 INIT: when CRDT_INIT=0, go to RUN next cycle; an update in that same cycle SHALL still be counted.
REQ-012 On INIT->RUN, if the counter (including the final-cycle update) is 0, INFINITE SHALL be set and held until the next INIT or reset.
REQ-013 RUN: TX_GRANT = TX_REQ and (INFINITE or CREDITS >= TX_REQ_CNT); combinational, evaluated against the registered count only.
REQ-014 TX_GRANT SHALL be 0 in IDLE and INIT regardless of TX_REQ.
REQ-015 RUN counter update: next = CREDITS + (CRDT_UPDATE ? CNT : 0) - (TX_GRANT ? TX_REQ_CNT : 0).
- Same-cycle update and grant SHALL both be applied.
- Credits returned in a cycle SHALL be usable no earlier than the next cycle.
REQ-016 Arithmetic SHALL be done at CRDT_WIDTH+1 bits.
- A result above 2^CRDT_WIDTH-1 SHALL saturate to 2^CRDT_WIDTH-1 and set OVERFLOW.
- OVERFLOW SHALL be cleared only by reset.
REQ-017 In INFINITE mode the counter SHALL not be decremented; updates SHALL still be added, with saturation.
REQ-018 TX_REQ_CNT=0 with TX_REQ=1 in RUN SHALL grant with no counter change.
REQ-019 CRDT_INIT=1 in RUN SHALL abort, with no grant in that cycle.
- Go to INIT next cycle; clear the counter and INFINITE.
- Pulse CRDT_INIT_ACK per REQ-009.
- Updates in the abort cycle SHALL be discarded.
REQ-020 READY SHALL equal (state == RUN); CREDITS SHALL equal the registered counter.

Reset
REQ-021 RESET=1 SHALL asynchronously force:
- state IDLE;
- CREDITS=0, INFINITE=0, OVERFLOW=0, CRDT_INIT_ACK=0;
- TX_GRANT=0 and READY=0, combinationally.
REQ-022 Reset asserted mid-INIT or mid-RUN SHALL discard all credits; after release, operation restarts from IDLE and requires a new CRDT_INIT.

Verification
REQ-023 Init: CRDT_INIT high for 4 cycles with updates 3,3,2,0 -> one ACK pulse at INIT+1, then RUN with CREDITS=8 and INFINITE=0.
REQ-024 Infinite mode: init with no updates -> INFINITE=1; 100 consecutive requests of 15 all granted; CREDITS stays 0.
REQ-025 Starvation and same-cycle update:
- CREDITS=2, TX_REQ_CNT=4 held -> no grant.
- Update of 3 -> still no grant in that cycle; grant next cycle; CREDITS goes 5 then 1.
REQ-026 Saturation: CRDT_WIDTH=4, CREDITS=14, update of 3 -> CREDITS=15 and OVERFLOW=1, persisting through later traffic.
REQ-027 Mid-RUN re-init: CRDT_INIT asserted with TX_REQ pending -> no grant, ACK pulse, CREDITS=0; re-accumulates correctly.
REQ-028 Async reset during RUN with CREDITS=9 -> outputs reach reset values without a clock edge; no grant until a new init completes.
